mips_mem_responder: RTL and testbench

Memory-side responder for the pipelined MIPS core: serves instruction fetch from a read-only instruction array and data-port loads/stores from a data array, fronted by a small store buffer. It sits opposite the core's `pc`/`instr` and data-RAM ports: it consumes `pc`, the store strobe, address and write data, and produces `instr`, load data and a back-pressure stall. Stores are posted into a FIFO and drained to the array on cycles without a load; loads forward from the buffer.

---
 rtl/mips_mem_responder.sv | 101 ++++++++++
 tb/tb_mips_mem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the pipelined MIPS core: combinational fetch, data loads/stores.
// Define MEM_STORE_BUF_EN to post stores through a forwarding FIFO; otherwise stores write dmem directly.
module mips_mem_responder #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc,
  output logic [31:0]              instr,
  input  logic                     mem_we,
  input  logic                     mem_re,
  input  logic [31:0]              data_addr,
  input  logic [31:0]              data_wdata,
  output logic [31:0]              data_rdata,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     misalign
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   imem [2**AW];
  logic [31:0]   dmem [2**AW];
  logic [AW-1:0] fetchIdx;
  logic [AW-1:0] dataIdx;
  logic [31:0]   loadWord;
  logic          unusedBits;

  // Upper address bits wrap; the byte offset only feeds misalign.
  assign fetchIdx   = pc[AW+1:2];
  assign dataIdx    = data_addr[AW+1:2];
  assign unusedBits = ^{pc[31:AW+2], pc[1:0], data_addr[31:AW+2]};

  assign instr      = rst ? imem[fetchIdx] : '0;
  assign data_rdata = rst ? loadWord : '0;
  assign misalign   = rst & (mem_we | mem_re) & (data_addr[1:0] != 2'b00);

`ifdef MEM_STORE_BUF_EN
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] bufIdx  [DEPTH];
  logic [31:0]   bufData [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic [PW-1:0] slot;

  // Store handshake: mem_we is valid, !stall is ready; a store transfers on an edge
  // where both hold. A stalled store is dropped here and re-presented by the core.
  assign stall     = rst & mem_we & mem_re & (count == FULL);
  assign push      = mem_we & ~stall;
  assign pop       = (count != '0) & ~mem_re;
  assign buf_count = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      bufIdx[wrPtr]  <= dataIdx;
      bufData[wrPtr] <= data_wdata;
    end
    if (rst && pop) dmem[bufIdx[rdPtr]] <= bufData[rdPtr];
  end

  // Walk oldest to youngest so the youngest matching entry overrides the rest.
  always_comb begin
    loadWord = dmem[dataIdx];
    slot     = rdPtr;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rdPtr + PW'(i);
      if (((PW+1)'(i) < count) && (bufIdx[slot] == dataIdx)) loadWord = bufData[slot];
    end
  end
`else
  assign stall     = 1'b0;
  assign buf_count = '0;
  assign loadWord  = dmem[dataIdx];

  always_ff @(posedge clk) begin
    if (rst && mem_we) dmem[dataIdx] <= data_wdata;
  end
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized and directed bench for mips_mem_responder against a queue/array reference model.
// Builds for either setting of MEM_STORE_BUF_EN.
module tb_mips_mem_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int NINIT = 32;
`ifdef MEM_STORE_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, data_addr, data_wdata;
  logic        mem_we, mem_re;
  logic [31:0] instr, data_rdata;
  logic        stall, misalign;
  logic [$clog2(DEPTH):0] buf_count;

  mips_mem_responder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .mem_we(mem_we), .mem_re(mem_re), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .stall(stall),
    .buf_count(buf_count), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference model: word arrays plus a FIFO of pending {index, data} stores.
  logic [31:0]    imemM [2**AW];
  logic [31:0]    dmemM [2**AW];
  logic [AW+31:0] exp_q [$];
  logic [31:0]    expInstr, expRdata;
  logic           expStall, expMis;
  int             expCount;
  int             nVec = 0;
  int             nFail = 0;

  function automatic logic [31:0] modelLoad(input logic [31:0] a);
    logic [AW-1:0] idx;
    idx = a[AW+1:2];
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][AW+31:32] == idx) return exp_q[i][31:0];
    return dmemM[idx];
  endfunction

  function automatic logic modelStall();
    return BUF && mem_we && mem_re && (exp_q.size() == DEPTH);
  endfunction

  function automatic void modelEdge();
    logic           st;
    logic [AW+31:0] e;
    st = modelStall();
    if (BUF) begin
      if (exp_q.size() != 0 && !mem_re) begin
        e = exp_q.pop_front();
        dmemM[e[AW+31:32]] = e[31:0];
      end
      if (mem_we && !st) exp_q.push_back({data_addr[AW+1:2], data_wdata});
    end else if (mem_we) begin
      dmemM[data_addr[AW+1:2]] = data_wdata;
    end
  endfunction

  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pcv);
    @(negedge clk);
    mem_we = we; mem_re = re; data_addr = addr; data_wdata = wdata; pc = pcv;
    #1;
    expInstr = imemM[pcv[AW+1:2]];
    expRdata = modelLoad(addr);
    expStall = modelStall();
    expMis   = (we || re) && (addr[1:0] != 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    expCount = BUF ? exp_q.size() : 0;
  endtask

  task automatic drain();
    repeat (DEPTH + 1) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; mem_we = 1'b1; mem_re = 1'b0; pc = 32'h4;
    data_addr = 32'h13; data_wdata = 32'hCAFE_0001;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    nVec++; if (instr !== 32'h0) begin nFail++; $display("FAIL rst_instr got %h exp 0", instr); end
    nVec++; if (data_rdata !== 32'h0) begin nFail++; $display("FAIL rst_rdata got %h exp 0", data_rdata); end
    nVec++; if (buf_count !== '0) begin nFail++; $display("FAIL rst_count got %0d exp 0", buf_count); end
    nVec++; if (stall !== 1'b0) begin nFail++; $display("FAIL rst_stall got %b exp 0", stall); end
    nVec++; if (misalign !== 1'b0) begin nFail++; $display("FAIL rst_misalign got %b exp 0", misalign); end
    @(negedge clk);
    rst = 1'b1; mem_we = 1'b0; mem_re = 1'b1; data_addr = 32'h10;
    #1;
    nVec++; if (instr !== imemM[1]) begin nFail++; $display("FAIL rst_rel_instr got %h exp %h", instr, imemM[1]); end
    nVec++; if (data_rdata !== dmemM[4]) begin nFail++; $display("FAIL rst_nowrite got %h exp %h", data_rdata, dmemM[4]); end
    tick();
  endtask

  task automatic test_store_forward();
    drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h8);
    nVec++; if (stall !== 1'b0) begin nFail++; $display("FAIL sf_stall got %b exp 0", stall); end
    nVec++; if (instr !== expInstr) begin nFail++; $display("FAIL sf_instr got %h exp %h", instr, expInstr); end
    tick();
    nVec++; if (buf_count !== expCount) begin nFail++; $display("FAIL sf_count got %0d exp %0d", buf_count, expCount); end
    drive(1'b0, 1'b1, 32'h10, 32'h0, 32'hC);
    nVec++; if (data_rdata !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL sf_fwd got %h exp deadbeef", data_rdata); end
    tick();
    drive(1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    tick();
    nVec++; if (buf_count !== '0) begin nFail++; $display("FAIL sf_drained got %0d exp 0", buf_count); end
    drive(1'b0, 1'b1, 32'h10, 32'h0, 32'h0);
    nVec++; if (data_rdata !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL sf_array got %h exp deadbeef", data_rdata); end
    tick();
  endtask

  task automatic test_youngest();
    drive(1'b1, 1'b1, 32'h20, 32'h11, 32'h0); tick();
    drive(1'b1, 1'b1, 32'h20, 32'h22, 32'h0); tick();
    nVec++; if (buf_count !== expCount) begin nFail++; $display("FAIL yw_count got %0d exp %0d", buf_count, expCount); end
    drive(1'b0, 1'b1, 32'h20, 32'h0, 32'h0);
    nVec++; if (data_rdata !== 32'h22) begin nFail++; $display("FAIL yw_fwd got %h exp 22", data_rdata); end
    tick();
    drain();
    drive(1'b0, 1'b1, 32'h20, 32'h0, 32'h0);
    nVec++; if (data_rdata !== 32'h22) begin nFail++; $display("FAIL yw_array got %h exp 22", data_rdata); end
    nVec++; if (buf_count !== '0) begin nFail++; $display("FAIL yw_empty got %0d exp 0", buf_count); end
    tick();
  endtask

  task automatic test_full_stall();
    logic [31:0] v [5];
    for (int i = 0; i < 5; i++) v[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h40 + 32'(4 * i), v[i], 32'h0);
      tick();
    end
    drive(1'b1, 1'b1, 32'h50, v[4], 32'h0);
    nVec++; if (stall !== BUF) begin nFail++; $display("FAIL fs_stall got %b exp %b", stall, BUF); end
    nVec++; if (data_rdata !== expRdata) begin nFail++; $display("FAIL fs_rdata got %h exp %h", data_rdata, expRdata); end
    tick();
    nVec++; if (buf_count !== expCount) begin nFail++; $display("FAIL fs_count got %0d exp %0d", buf_count, expCount); end
    drive(1'b1, 1'b0, 32'h50, v[4], 32'h0);
    nVec++; if (stall !== 1'b0) begin nFail++; $display("FAIL fs_accept got %b exp 0", stall); end
    tick();
    nVec++; if (buf_count !== expCount) begin nFail++; $display("FAIL fs_count2 got %0d exp %0d", buf_count, expCount); end
    drain();
    drive(1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    nVec++; if (data_rdata !== v[0]) begin nFail++; $display("FAIL fs_oldest got %h exp %h", data_rdata, v[0]); end
    tick();
    drive(1'b0, 1'b1, 32'h50, 32'h0, 32'h0);
    nVec++; if (data_rdata !== v[4]) begin nFail++; $display("FAIL fs_fifth got %h exp %h", data_rdata, v[4]); end
    tick();
  endtask

  task automatic test_wrap_misalign();
    logic [31:0] v;
    v = $urandom;
    drive(1'b1, 1'b0, 32'h1000_0010, v, 32'h0); tick();
    drain();
    drive(1'b0, 1'b1, 32'h13, 32'h0, 32'h0);
    nVec++; if (misalign !== 1'b1) begin nFail++; $display("FAIL wm_mis got %b exp 1", misalign); end
    nVec++; if (data_rdata !== v) begin nFail++; $display("FAIL wm_wrap got %h exp %h", data_rdata, v); end
    tick();
    drive(1'b0, 1'b0, 32'h13, 32'h0, 32'h0);
    nVec++; if (misalign !== 1'b0) begin nFail++; $display("FAIL wm_idle got %b exp 0", misalign); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h60 + 32'(4 * i), $urandom, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h60, 32'h0, 32'h4);
    #2 rst = 1'b0;
    #1;
    nVec++; if (buf_count !== '0) begin nFail++; $display("FAIL rm_count got %0d exp 0", buf_count); end
    nVec++; if (instr !== 32'h0) begin nFail++; $display("FAIL rm_instr got %h exp 0", instr); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h60 + 32'(4 * i), 32'h0, 32'h0);
      nVec++; if (data_rdata !== expRdata) begin nFail++; $display("FAIL rm_load%0d got %h exp %h", i, data_rdata, expRdata); end
      tick();
    end
  endtask

  task automatic test_random();
    logic        we, re;
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 3) != 0);
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
      drive(we, re, a, $urandom, $urandom);
      nVec++; if (instr !== expInstr) begin nFail++; $display("FAIL rnd_instr n=%0d got %h exp %h", n, instr, expInstr); end
      nVec++; if (data_rdata !== expRdata) begin nFail++; $display("FAIL rnd_rdata n=%0d got %h exp %h", n, data_rdata, expRdata); end
      nVec++; if (stall !== expStall) begin nFail++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, stall, expStall); end
      nVec++; if (misalign !== expMis) begin nFail++; $display("FAIL rnd_mis n=%0d got %b exp %b", n, misalign, expMis); end
      tick();
      nVec++; if (buf_count !== expCount) begin nFail++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, buf_count, expCount); end
    end
    drain();
  endtask

  initial begin
    rst = 1'b0; mem_we = 1'b0; mem_re = 1'b0; pc = '0; data_addr = '0; data_wdata = '0;
    expCount = 0;
    for (int i = 0; i < 2**AW; i++) begin
      imemM[i] = $urandom;
      dut.imem[i] = imemM[i];
      dmemM[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NINIT; i++) begin
      drive(1'b1, 1'b0, 32'(4 * i), $urandom, 32'h0);
      tick();
    end
    drain();
    test_reset();
    test_store_forward();
    test_youngest();
    test_full_stall();
    test_wrap_misalign();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
